aes_round_ctrl: RTL

//  Round sequencer for the AES-128 datapath.
//  - Accepts a start request and runs INIT plus NR rounds, one round per clock.
//  - Drives the per-cycle strobes for the state register and the key-expansion stage.
//  - Generates the round number, RCON and the last-round flag.
//  - Holds the result valid until the consumer accepts it.
//  - Its ROUND/LAST_RND outputs feed the gate-level round-decode logic (AND4-class

---
 rtl/aes_round_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: walks INIT plus NR rounds one per clock, drives the
// state/key strobes with ROUND and RCON, and holds the result until it is accepted.
module aes_round_ctrl #(
   parameter int NR = 10,
   parameter int RW = 4
) (
   input  logic          CLK,
   input  logic          RSTB,
   input  logic          START,
   output logic          READY,
   output logic          LD_STATE,
   output logic          KEY_EN,
   output logic          EN_ROUND,
   output logic          LAST_RND,
   output logic [RW-1:0] ROUND,
   output logic [7:0]    RCON,
   output logic          OUT_VALID,
   input  logic          OUT_READY
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      RND   = 3'd2,
      FINAL = 3'd3,
      HOLD  = 3'd4
   } state_t;

   localparam logic [RW-1:0] ROUND_PEN = RW'(NR - 1);
   localparam logic [7:0]    RCON_1    = 8'h01;

   state_t        state, state_nxt;
   logic [RW-1:0] round_q, round_nxt;
   logic [7:0]    rcon_q, rcon_nxt;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   always_ff @(posedge CLK) begin
      if (!RSTB) begin
         state   <= IDLE;
         round_q <= '0;
         rcon_q  <= RCON_1;
      end else begin
         state   <= state_nxt;
         round_q <= round_nxt;
         rcon_q  <= rcon_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      round_nxt = round_q;
      rcon_nxt  = rcon_q;
      case (state)
         IDLE: begin
            if (START) begin
               state_nxt = INIT;
               round_nxt = '0;
               rcon_nxt  = RCON_1;
            end
         end
         INIT: begin
            state_nxt = RND;
            round_nxt = RW'(1);
            rcon_nxt  = RCON_1;
         end
         RND: begin
            round_nxt = round_q + RW'(1);
            rcon_nxt  = xtime(rcon_q);
            if (round_q == ROUND_PEN) begin
               state_nxt = FINAL;
            end
         end
         FINAL: begin
            state_nxt = HOLD;
         end
         HOLD: begin
            // ROUND/RCON stay frozen at the final round until the next INIT.
            if (OUT_READY) begin
               if (START) begin
                  state_nxt = INIT;
                  round_nxt = '0;
                  rcon_nxt  = RCON_1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            round_nxt = '0;
            rcon_nxt  = RCON_1;
         end
      endcase
   end

   assign READY     = (state == IDLE) || ((state == HOLD) && OUT_READY);
   assign LD_STATE  = (state == INIT);
   assign KEY_EN    = (state == RND) || (state == FINAL);
   assign EN_ROUND  = (state == RND) || (state == FINAL);
   assign LAST_RND  = (state == FINAL);
   assign OUT_VALID = (state == HOLD);
   assign ROUND     = round_q;
   assign RCON      = rcon_q;

endmodule
